// File: rtl/mul_sequencer.sv
// Multi-cycle sequencer for the 8-bit array multiplier: latches operands, waits
// LATENCY settle cycles, captures the low product byte and pulses done.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no multiply in flight; operands and result held
// ST_WAIT | operands stable at multiplier, settle counter running; busy=1
// ST_DONE | result captured this edge; done=1 for exactly one cycle
module mul_sequencer #(
  parameter int LATENCY = 2,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] operand1,
  input  logic [7:0] operand2,
  output logic [7:0] mul_a,
  output logic [7:0] mul_b,
  input  logic [7:0] mul_result,
  output logic [7:0] result,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // busy/done are flops set alongside the state so they never see start directly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      mul_a  <= 8'h00;
      mul_b  <= 8'h00;
      result <= 8'h00;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mul_a <= operand1;
            mul_b <= operand2;
            cnt   <= CNT_INIT;
            busy  <= 1'b1;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            result <= mul_result;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done <= 1'b0;
          // back-to-back issue: accept the next request without an idle bubble
          if (start) begin
            mul_a <= operand1;
            mul_b <= operand2;
            cnt   <= CNT_INIT;
            busy  <= 1'b1;
            state <= ST_WAIT;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: default LATENCY=2 instance plus a LATENCY=1
// instance, each wired to a behavioural 8x8 multiplier.
module tb_mul_sequencer;

  logic       clk;
  logic       reset;
  logic       start,  start2;
  logic [7:0] op1, op2, op1_2, op2_2;
  logic [7:0] mul_a, mul_b, mres, result;
  logic [7:0] mul_a2, mul_b2, mres2, result2;
  logic       busy, done, busy2, done2;
  logic [15:0] prod, prod2;

  int n_cmp = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign prod  = 16'(mul_a)  * 16'(mul_b);
  assign prod2 = 16'(mul_a2) * 16'(mul_b2);
  assign mres  = prod[7:0];
  assign mres2 = prod2[7:0];

  mul_sequencer #(.LATENCY(2), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start),
    .operand1(op1), .operand2(op2),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mres),
    .result(result), .busy(busy), .done(done)
  );

  mul_sequencer #(.LATENCY(1), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .start(start2),
    .operand1(op1_2), .operand2(op2_2),
    .mul_a(mul_a2), .mul_b(mul_b2), .mul_result(mres2),
    .result(result2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // issue one multiply with start dropped after the accepting edge
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp, input string tag);
    int  bc;
    bit  seen;
    @(negedge clk);
    start = 1'b1; op1 = a; op2 = b;
    @(negedge clk);
    start = 1'b0; op1 = 8'h00; op2 = 8'h00;
    bc = 0; seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (busy) bc++;
      chk({tag, "_overlap"}, {31'd0, busy & done}, 32'd0);
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    chk({tag, "_busy_cycles"}, bc, 32'd2);
    chk({tag, "_result"}, {24'd0, result}, {24'd0, exp});
    @(negedge clk);
    chk({tag, "_done_fall"}, {31'd0, done}, 32'd0);
    chk({tag, "_result_hold"}, {24'd0, result}, {24'd0, exp});
  endtask

  initial begin
    int dcnt;
    reset = 1'b1; start = 1'b0; start2 = 1'b0;
    op1 = 8'h00; op2 = 8'h00; op1_2 = 8'h00; op2_2 = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_result", {24'd0, result}, 32'd0);
    chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
    chk("rst_mul_ab", {16'd0, mul_a, mul_b}, 32'd0);
    reset = 1'b0;

    // basic and wrap-around products
    run_op(8'd5,  8'd6,  8'h1E, "t1_5x6");
    run_op(8'd16, 8'd16, 8'h00, "t2_16x16");
    run_op(8'hFF, 8'hFF, 8'h01, "t2_ffxff");
    run_op(8'hFD, 8'h04, 8'hF4, "t2_neg3x4");

    // back-to-back with start held high
    @(negedge clk);
    start = 1'b1; op1 = 8'd3; op2 = 8'd7;
    @(negedge clk);
    chk("t3_busy_e0", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("t3_busy_e1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("t3_done1", {30'd0, busy, done}, 32'd1);
    chk("t3_result1", {24'd0, result}, 32'h15);
    op1 = 8'd9; op2 = 8'd9;
    @(negedge clk);
    chk("t3_no_bubble", {30'd0, busy, done}, 32'd2);
    chk("t3_mul_ab2", {16'd0, mul_a, mul_b}, 32'h0909);
    @(negedge clk);
    chk("t3_busy_e4", {31'd0, busy}, 32'd1);
    start = 1'b0;
    @(negedge clk);
    chk("t3_done2", {30'd0, busy, done}, 32'd1);
    chk("t3_result2", {24'd0, result}, 32'h51);
    @(negedge clk);
    chk("t3_idle", {30'd0, busy, done}, 32'd0);

    // start and operand changes ignored during WAIT
    @(negedge clk);
    start = 1'b1; op1 = 8'd12; op2 = 8'd11;
    @(negedge clk);
    op1 = 8'd2; op2 = 8'd2;
    chk("t4_hold_e0", {16'd0, mul_a, mul_b}, 32'h0C0B);
    @(negedge clk);
    chk("t4_hold_e1", {16'd0, mul_a, mul_b}, 32'h0C0B);
    start = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) dcnt++;
      if (i == 0) chk("t4_result", {24'd0, result}, 32'h84);
    end
    chk("t4_done_pulses", dcnt, 32'd1);
    chk("t4_hold_end", {16'd0, mul_a, mul_b}, 32'h0C0B);

    // asynchronous reset in the middle of WAIT
    @(negedge clk);
    start = 1'b1; op1 = 8'd7; op2 = 8'd7;
    @(negedge clk);
    start = 1'b0;
    chk("t5_busy_before", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_outs", {mul_a, mul_b, result, 6'd0, busy, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy || result != 8'h00) dcnt++;
    end
    chk("t5_quiet_after", dcnt, 32'd0);

    // LATENCY=1 instance
    @(negedge clk);
    start2 = 1'b1; op1_2 = 8'd10; op2_2 = 8'd12;
    @(negedge clk);
    start2 = 1'b0;
    chk("t6_busy", {30'd0, busy2, done2}, 32'd2);
    @(negedge clk);
    chk("t6_done", {30'd0, busy2, done2}, 32'd1);
    chk("t6_result", {24'd0, result2}, 32'h78);
    @(negedge clk);
    chk("t6_done_fall", {30'd0, busy2, done2}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
